// File: rtl/change_dispenser.sv
// change_dispenser: greedy high/low coin payout sequencer with hopper handshake and inventory tracking
module change_dispenser #(
    parameter int DENOM_HI       = 5,
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int INV_WIDTH      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           amount,
    input  logic                 inv_load,
    input  logic [INV_WIDTH-1:0] inv_hi_in,
    input  logic [INV_WIDTH-1:0] inv_lo_in,
    input  logic                 coin_sensed,
    output logic                 eject_hi,
    output logic                 eject_lo,
    output logic                 busy,
    output logic                 done,
    output logic                 fault,
    output logic [7:0]           remaining,
    output logic [INV_WIDTH-1:0] inv_hi,
    output logic [INV_WIDTH-1:0] inv_lo
);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] DH = 8'(DENOM_HI);

    typedef enum logic [2:0] {IDLE, SELECT, EJECT, WAIT_SENSE, DONE, FAULT} state_t;

    state_t        state, state_nx;
    logic          sel_hi, seen;
    logic [PW-1:0] pcnt;
    logic [TW-1:0] tmr;
    logic          idle_like, take_hi, credit, pulse_end;

    assign idle_like = state == IDLE || state == FAULT;
    assign take_hi   = remaining >= DH && inv_hi != '0;
    assign credit    = (state == EJECT || state == WAIT_SENSE) && coin_sensed && !seen;
    assign pulse_end = pcnt == PW'(PULSE_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, FAULT: state_nx = start ? (amount != '0 ? SELECT : DONE) : state;
            SELECT:      state_nx = remaining == '0 ? DONE :
                                    (take_hi || inv_lo != '0) ? EJECT : FAULT;
            EJECT:       state_nx = !pulse_end ? EJECT : (seen || coin_sensed) ? SELECT : WAIT_SENSE;
            WAIT_SENSE:  state_nx = coin_sensed ? SELECT :
                                    tmr == TW'(TIMEOUT_CYCLES - 1) ? FAULT : WAIT_SENSE;
            DONE:        state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end

    always_comb begin
        eject_hi = state == EJECT && sel_hi;
        eject_lo = state == EJECT && !sel_hi;
        busy     = state == SELECT || state == EJECT || state == WAIT_SENSE;
        done     = state == DONE;
        fault    = state == FAULT;
    end

    // Only the first sense per coin is credited; seen is cleared in SELECT, just before EJECT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            remaining <= '0;
            inv_hi    <= '0;
            inv_lo    <= '0;
            sel_hi    <= 1'b0;
            seen      <= 1'b0;
            pcnt      <= '0;
            tmr       <= '0;
        end else begin
            if (idle_like && inv_load) begin
                inv_hi <= inv_hi_in;
                inv_lo <= inv_lo_in;
            end
            if (idle_like && start) remaining <= amount;
            if (state == SELECT) begin
                sel_hi <= take_hi;
                seen   <= 1'b0;
                pcnt   <= '0;
            end
            if (state == EJECT) begin
                pcnt <= pcnt + PW'(1);
                tmr  <= '0;
            end
            if (state == WAIT_SENSE) tmr <= tmr + TW'(1);
            if (credit) begin
                remaining <= remaining - (sel_hi ? DH : 8'd1);
                seen      <= 1'b1;
                if (sel_hi && inv_hi != '0) inv_hi <= inv_hi - INV_WIDTH'(1);
                if (!sel_hi && inv_lo != '0) inv_lo <= inv_lo - INV_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed payouts checked every cycle against a coin-level model
module tb_change_dispenser;
    localparam int DH = 5, PC = 4, TO = 16, IW = 6;

    logic clk = 0, rst = 0, start = 0, inv_load = 0, auto_en = 0, auto_s = 0, man_s = 0;
    logic [7:0] amount = 0;
    logic [IW-1:0] inv_hi_in = 0, inv_lo_in = 0;
    logic coin_sensed, eject_hi, eject_lo, busy, done, fault;
    logic [7:0] remaining;
    logic [IW-1:0] inv_hi, inv_lo;

    assign coin_sensed = auto_s | man_s;
    always #5 clk = ~clk;

    change_dispenser #(.DENOM_HI(DH), .PULSE_CYCLES(PC), .TIMEOUT_CYCLES(TO), .INV_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .amount(amount), .inv_load(inv_load),
        .inv_hi_in(inv_hi_in), .inv_lo_in(inv_lo_in), .coin_sensed(coin_sensed),
        .eject_hi(eject_hi), .eject_lo(eject_lo), .busy(busy), .done(done), .fault(fault),
        .remaining(remaining), .inv_hi(inv_hi), .inv_lo(inv_lo)
    );

    int n_tests = 0, n_fail = 0;
    int hi_rises = 0, lo_rises = 0;
    logic p_hi = 0, p_lo = 0, r1 = 0, r2 = 0;

    // model: mode 0 idle, 1 choosing, 2 pulsing, 3 waiting, 4 done, 5 fault
    int m_mode = 0, m_age = 0, m_coin = 1;
    bit m_seen = 0;
    logic [7:0] m_rem = 0;
    logic [IW-1:0] m_hi = 0, m_lo = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pay();
        m_rem  = m_rem - 8'(m_coin);
        if (m_coin == DH) m_hi = m_hi - 1;
        else m_lo = m_lo - 1;
        m_seen = 1;
    endtask

    task automatic model_step();
        if (!rst) begin
            m_mode = 0; m_age = 0; m_seen = 0; m_rem = 0; m_hi = 0; m_lo = 0; m_coin = 1;
        end else case (m_mode)
            0, 5: begin
                if (inv_load) begin m_hi = inv_hi_in; m_lo = inv_lo_in; end
                if (start) begin m_rem = amount; m_mode = amount != 0 ? 1 : 4; end
            end
            1: begin
                m_age = 0; m_seen = 0;
                if (m_rem == 0) m_mode = 4;
                else if (m_rem >= DH && m_hi > 0) begin m_coin = DH; m_mode = 2; end
                else if (m_lo > 0) begin m_coin = 1; m_mode = 2; end
                else m_mode = 5;
            end
            2: begin
                if (coin_sensed && !m_seen) pay();
                if (m_age == PC - 1) begin m_mode = m_seen ? 1 : 3; m_age = 0; end
                else m_age++;
            end
            3: begin
                if (coin_sensed) begin pay(); m_mode = 1; end
                else if (m_age == TO - 1) m_mode = 5;
                else m_age++;
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic tick();
        logic [24:0] exp;
        @(posedge clk);
        model_step();
        #1;
        exp = {m_mode == 2 && m_coin == DH, m_mode == 2 && m_coin == 1, m_mode inside {1, 2, 3},
               m_mode == 4, m_mode == 5, m_rem, m_hi, m_lo};
        check("cycle", 32'({eject_hi, eject_lo, busy, done, fault, remaining, inv_hi, inv_lo}), 32'(exp));
        if (eject_hi && !p_hi) hi_rises++;
        if (eject_lo && !p_lo) lo_rises++;
        auto_s = auto_en && r2;
        r2 = r1;
        r1 = (eject_hi && !p_hi) || (eject_lo && !p_lo);
        p_hi = eject_hi;
        p_lo = eject_lo;
    endtask

    task automatic go(input logic [7:0] a);
        start = 1; amount = a;
        tick();
        start = 0;
    endtask

    task automatic load(input logic [IW-1:0] h, input logic [IW-1:0] l);
        inv_load = 1; inv_hi_in = h; inv_lo_in = l;
        tick();
        inv_load = 0;
    endtask

    // which: 0 done, 1 fault, 2 eject_hi, 3 eject_lo
    task automatic wait_for(input int which, input int budget);
        logic hit;
        for (int i = 0; i < budget; i++) begin
            hit = which == 0 ? done : which == 1 ? fault : which == 2 ? eject_hi : eject_lo;
            if (hit) return;
            tick();
        end
        check($sformatf("wait_timeout_%0d", which), 0, 1);
    endtask

    initial begin
        int bh, bl, n, m;
        tick(); tick();
        check("reset_state", 32'({eject_hi, eject_lo, busy, done, fault, remaining, inv_hi, inv_lo}), 0);
        rst = 1;
        tick();

        // normal payout 7 = 5 + 1 + 1
        auto_en = 1; bh = hi_rises; bl = lo_rises;
        load(3, 5);
        go(7);
        wait_for(0, 200);
        check("normal_done", 32'(done), 1);
        check("normal_rem", 32'(remaining), 0);
        check("normal_inv_hi", 32'(inv_hi), 2);
        check("normal_inv_lo", 32'(inv_lo), 3);
        check("normal_hi_ejects", 32'(hi_rises - bh), 1);
        check("normal_lo_ejects", 32'(lo_rises - bl), 2);
        tick();

        // insufficient coins: 12 with one hi and three lo leaves 4 unpaid
        bh = hi_rises; bl = lo_rises;
        load(1, 3);
        go(12);
        wait_for(1, 300);
        check("short_fault", 32'(fault), 1);
        check("short_busy", 32'(busy), 0);
        check("short_rem", 32'(remaining), 4);
        check("short_inv", 32'({inv_hi, inv_lo}), 0);
        check("short_hi_ejects", 32'(hi_rises - bh), 1);
        check("short_lo_ejects", 32'(lo_rises - bl), 3);
        go(0);
        check("fault_clear_done", 32'({fault, done}), 1);
        tick();

        // jam: no sense at all
        auto_en = 0;
        load(2, 2);
        go(5);
        wait_for(2, 20);
        n = 0;
        while (eject_hi && n < 50) begin n++; tick(); end
        check("jam_pulse_len", 32'(n), PC);
        m = 0;
        while (!fault && m < 100) begin tick(); m++; end
        check("jam_timeout", 32'(m), TO);
        check("jam_rem", 32'(remaining), 5);
        check("jam_inv_hi", 32'(inv_hi), 2);
        go(0);
        tick();

        // zero amount, then ignored start and ignored load mid-payout
        bh = hi_rises; bl = lo_rises;
        go(0);
        check("zero_done", 32'(done), 1);
        tick();
        auto_en = 1;
        load(3, 5);
        go(7);
        tick(); tick();
        go(3);
        load(9, 9);
        wait_for(0, 200);
        check("ignored_rem", 32'(remaining), 0);
        check("ignored_inv", 32'({inv_hi, inv_lo}), 32'({6'd2, 6'd3}));
        check("ignored_ejects", 32'(hi_rises - bh + lo_rises - bl), 3);
        tick();

        // duplicate sense within one eject, then spurious sense in idle
        auto_en = 0;
        load(2, 2);
        go(2);
        wait_for(3, 20);
        man_s = 1; tick(); man_s = 0; tick(); man_s = 1; tick(); man_s = 0; tick();
        check("dup_rem", 32'(remaining), 1);
        check("dup_inv_lo", 32'(inv_lo), 1);
        wait_for(3, 20);
        man_s = 1; tick(); man_s = 0;
        wait_for(0, 50);
        check("dup_done_inv", 32'({remaining, inv_lo}), 0);
        tick();
        man_s = 1; tick(); man_s = 0; tick();
        check("spurious_idle", 32'({remaining, inv_hi, inv_lo}), 32'({8'd0, 6'd2, 6'd0}));

        // reset during a low-coin eject
        auto_en = 1;
        load(0, 3);
        go(2);
        wait_for(3, 20);
        rst = 0;
        tick();
        rst = 1;
        check("rst_mid", 32'({eject_lo, busy, remaining, inv_hi, inv_lo}), 0);
        load(1, 1);
        go(6);
        wait_for(0, 200);
        check("post_rst_pay", 32'({remaining, inv_hi, inv_lo}), 0);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
